// File: rtl/icache_direct_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef logic [255:0] cacheline_t;

  localparam int S_OFFSET_DEF = 5;
  localparam int S_INDEX_DEF  = 4;
  localparam int S_TAG_DEF    = 32 - S_INDEX_DEF - S_OFFSET_DEF;

endpackage

// File: rtl/icache_direct_if.sv
// Simple read request/response bus; used for both the fetch side and the line-fill side.
interface icache_direct_if #(
  parameter int DW = 32
) ();
  logic          read;
  logic [31:0]   address;
  logic [DW-1:0] rdata;
  logic          resp;

  modport master (output read, output address, input rdata, input resp);
  modport slave  (input read, input address, output rdata, output resp);
endinterface

// File: rtl/icache_direct_array.sv
// Register-file storage for one cache field: asynchronous read, synchronous write.
// Only instances with RST_EN set are cleared by rst (the valid bits).
module icache_array #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1,
  parameter bit RST_EN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [S_INDEX-1:0] rindex,
  input  logic [S_INDEX-1:0] windex,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);
  localparam int DEPTH = 1 << S_INDEX;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (load) mem_d[windex] = wdata;
  end

  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[rindex];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, one-line fills on miss.
// Optional performance counters enabled by defining ICACHE_PERF_CNT_EN.
//
// state | meaning
// IDLE  | lookup; respond on hit, latch miss line address on miss
// FILL  | pmem_read held until pmem_resp writes the line
module icache_direct
  import icache_types_pkg::*;
#(
  parameter int S_OFFSET = S_OFFSET_DEF,
  parameter int S_INDEX  = S_INDEX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  icache_direct_if.slave    imem,
  icache_direct_if.master   pmem,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
  localparam int LINE_W = 8 << S_OFFSET;
  localparam int WORDS  = LINE_W / 32;
  localparam int S_WORD = S_OFFSET - 2;

  icache_state_t state_q, state_d;
  logic [S_TAG+S_INDEX-1:0] miss_addr_q, miss_addr_d;
  logic pmem_read_q, pmem_read_d;
  logic miss_evt, fill_done, load, lookup_hit, hit;

  logic [S_TAG-1:0]   addr_tag;
  logic [S_INDEX-1:0] addr_idx;
  logic [S_WORD-1:0]  addr_word;
  logic [1:0]         unused_addr_lo;

  logic [0:0]                 valid_rd;
  logic [S_TAG-1:0]           tag_rd;
  logic [WORDS-1:0][31:0]     data_rd;

  assign addr_tag       = imem.address[31 -: S_TAG];
  assign addr_idx       = imem.address[S_OFFSET +: S_INDEX];
  assign addr_word      = imem.address[2 +: S_WORD];
  assign unused_addr_lo = imem.address[1:0];

  // A fill coinciding with reset is discarded.
  assign load = fill_done && !rst;

  icache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .RST_EN(1'b1)) u_valid (
    .clk, .rst, .load,
    .rindex (addr_idx),
    .windex (miss_addr_q[S_INDEX-1:0]),
    .wdata  (1'b1),
    .rdata  (valid_rd)
  );

  icache_array #(.S_INDEX(S_INDEX), .WIDTH(S_TAG), .RST_EN(1'b0)) u_tag (
    .clk, .rst, .load,
    .rindex (addr_idx),
    .windex (miss_addr_q[S_INDEX-1:0]),
    .wdata  (miss_addr_q[S_INDEX +: S_TAG]),
    .rdata  (tag_rd)
  );

  icache_array #(.S_INDEX(S_INDEX), .WIDTH(LINE_W), .RST_EN(1'b0)) u_data (
    .clk, .rst, .load,
    .rindex (addr_idx),
    .windex (miss_addr_q[S_INDEX-1:0]),
    .wdata  (pmem.rdata),
    .rdata  (data_rd)
  );

  assign hit        = valid_rd[0] && (tag_rd == addr_tag);
  assign lookup_hit = !rst && (state_q == IDLE) && imem.read && hit;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    pmem_read_d = pmem_read_q;
    miss_evt    = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (imem.read && !hit) begin
          state_d     = FILL;
          miss_addr_d = {addr_tag, addr_idx};
          pmem_read_d = 1'b1;
          miss_evt    = 1'b1;
        end
      end
      FILL: begin
        if (pmem.resp) begin
          state_d     = IDLE;
          pmem_read_d = 1'b0;
          fill_done   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      pmem_read_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      pmem_read_q <= pmem_read_d;
    end
  end

  assign imem.resp    = lookup_hit;
  assign imem.rdata   = lookup_hit ? data_rd[addr_word] : 32'h0;
  assign pmem.read    = pmem_read_q;
  assign pmem.address = {miss_addr_q, {S_OFFSET{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + 32'(lookup_hit);
    miss_cnt_d = miss_cnt_q + 32'(miss_evt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache sitting directly upstream of the pipelined RV32I datapath's fetch stage: it turns the datapath's word-wide `imem_address` into `imem_rdata`, and fills from physical memory one 256-bit line at a time. Hits return in the same cycle. Misses stall fetch through `imem_resp` until the line is filled.

## Interface
- `S_OFFSET`, default 5: byte-offset bits; line is 2^5 = 32 B = 256 bits.
- `S_INDEX`, default 4: index bits; 16 sets.
- Derived: `S_TAG` = 32 − S_INDEX − S_OFFSET = 23.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_read`  in  1: fetch request; address must be held stable until `imem_resp`.
- `imem_address`  in  32: byte address; bits [1:0] are ignored.
- `imem_rdata`  out  32: fetched instruction; valid only while `imem_resp` = 1.
- `imem_resp`  out  1: request complete this cycle.
- `pmem_read`  out  1: line-fill request; held until `pmem_resp`.
- `pmem_address`  out  32: line-aligned fill address (low S_OFFSET bits are 0).
- `pmem_rdata`  in  256: fill data; sampled in the `pmem_resp` cycle.
- `pmem_resp`  in  1: fill data valid; a one-cycle pulse.
- `hit_count`  out  32: performance counter (see Configuration).
- `miss_count`  out  32: performance counter (see Configuration).

## Operation
- Address split: tag = [31:9], index = [8:5], word = [4:2].
- `hit` = `valid[index]` && `tag[index]` == addr tag.
- FSM states: IDLE, FILL.
  - IDLE: if `imem_read` && `hit`, then `imem_resp` = 1 and `imem_rdata` = `line[index][word*32 +: 32]`. This path is combinational from the arrays.
  - IDLE, `imem_read` && !`hit`: latch `{tag, index}` into `miss_addr` and go to FILL. `imem_resp` stays 0.
  - FILL: `pmem_read` = 1 and `pmem_address` = `{miss_addr, 5'b0}`.
  - FILL, on `pmem_resp`: write the data line, tag and valid at `miss_addr`'s index, overwriting unconditionally (direct-mapped eviction, no writeback). Go to IDLE.
- After the fill, the IDLE lookup hits and responds.
- If `imem_address` changes during FILL (illegal), the fill still completes for `miss_addr`. The next IDLE cycle looks up the new address.
- `imem_read` = 0 in IDLE: no action; `imem_resp` = 0.
- Arrays: valid bits are cleared by `rst`. Tag and data arrays are not reset.

## Timing
- Reset values: state IDLE, all valid = 0, `pmem_read` = 0, `pmem_address` = 0, `imem_resp` = 0, `imem_rdata` = 0 while not responding, counters = 0.
- Hit latency: 0 cycles (response in the request cycle).
- Miss latency: 1 (IDLE detect) + N (FILL, N ≥ 1 cycles until `pmem_resp`) + 1 (IDLE hit).
  - Minimum is 3 cycles from first request to `imem_resp`.
- `pmem_read` rises the cycle after the miss is detected. It falls the cycle after `pmem_resp`.
- `rst` during FILL: return to IDLE, drop `pmem_read` next cycle, clear valid, discard any concurrent `pmem_resp`.
- A `pmem_resp` arriving in IDLE is ignored.
- Write and read of the same set in one cycle cannot occur, because a fill happens only in FILL.

## Configuration
- `ICACHE_PERF_CNT_EN` defined:
  - `hit_count` increments on every IDLE cycle with `imem_read` && `hit`.
  - `miss_count` increments on every IDLE→FILL transition.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by `rst`.
  - The post-fill hit is counted as a hit.
- Not defined: both ports are tied to 0 and no counter flops are synthesized.

## Structure
- Package `icache_types_pkg` holds:
  - `icache_state_t` enum {IDLE, FILL};
  - `cacheline_t` (logic [255:0]);
  - localparams for default S_OFFSET, S_INDEX, S_TAG.
- Sub-module `icache_array`: valid/tag/data storage.
  - Parameterised by S_INDEX and width.
  - Asynchronous read, synchronous write with `load` and `rst` (rst clears the valid instance only).
  - Instantiated three times.
- The top level holds the FSM, `miss_addr`, output muxing and the optional counters.

## Test plan
- Cold miss: `rst`, then `imem_read` at 0x4000_0000; `pmem_resp` after 2 cycles with line word0 = 0x0000_0013.
  - Expect `pmem_address` = 0x4000_0000 and `imem_resp` at cycle 4 with rdata 0x0000_0013.
  - Expect `miss_count` = 1.
- Same-line hits: after the fill, read 0x4000_0004 through 0x4000_001C.
  - Expect `imem_resp` each same cycle, correct words, and `pmem_read` never asserted.
  - Expect `hit_count` = 8 (including the post-fill hit of 0x4000_0000).
- Conflict eviction: fill 0x4000_0000, then read 0x4000_0200 (same index 0, different tag).
  - Expect a new fill at 0x4000_0200.
  - Re-reading 0x4000_0000 misses again.
- Reset mid-fill: assert `rst` for 1 cycle during FILL, with `pmem_resp` in the same cycle.
  - Expect `pmem_read` = 0 next cycle and the line not valid; a subsequent read of the same address misses.
- Variable memory latency: `pmem_resp` delays of 1 and 10 cycles.
  - Expect `pmem_read` and `pmem_address` stable throughout FILL, and `imem_resp` exactly 1 cycle after `pmem_resp`.
- Macro off: repeat the cold-miss test; expect `hit_count` = `miss_count` = 0.
